drr_req_gen: RTL and testbench

- Request-initiator side of the DRR rank engine.
- Accepts per-packet descriptors (class id, packet length) from the parser/ingress path.
- Looks up the class quantum in a local weight table and computes pkt_len / weight with a sequential restoring divider.
- Issues the one-cycle req_valid/class/weight/quotient/remainder request the DRR engine consumes. The engine has no back-pressure, so this block is the sole pacing point.

---
 rtl/drr_req_gen_pkg.sv | 22 ++
 rtl/drr_req_gen_div.sv | 62 ++++++
 rtl/drr_req_gen.sv | 142 ++++++++++++++
 tb/tb_drr_req_gen.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/drr_req_gen_pkg.sv
// Shared defaults and FSM state encoding for the DRR request generator.
// No logic; imported by the generator and its divider.
package drr_req_gen_pkg;

    localparam int DFLT_CLASS_WIDTH   = 5;
    localparam int DFLT_WEIGHT_WIDTH  = 16;
    localparam int DFLT_PKT_WIDTH     = 16;
    localparam int DFLT_DEFAULT_WEIGHT = 1500;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LOOKUP = 2'd1;
    localparam logic [1:0] DIV    = 2'd2;
    localparam logic [1:0] EMIT   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = IDLE,
        ST_LOOKUP = LOOKUP,
        ST_DIV    = DIV,
        ST_EMIT   = EMIT
    } state_t;

endpackage

// File: rtl/drr_req_gen_div.sv
// Sequential restoring divider, one quotient bit per cycle, MSB first.
// Latency: DVD_WIDTH cycles after start; done is high during the final step.
// No backpressure: start restarts the divider, quotient/remainder are valid while done.
module seq_restoring_div
    import drr_req_gen_pkg::*;
#(
    parameter int DVD_WIDTH = DFLT_PKT_WIDTH,
    parameter int DVS_WIDTH = DFLT_WEIGHT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [DVD_WIDTH-1:0] dividend,
    input  logic [DVS_WIDTH-1:0] divisor,
    output logic                 done,
    output logic [DVD_WIDTH-1:0] quotient,
    output logic [DVS_WIDTH-1:0] remainder
);

    localparam int CNT_WIDTH = (DVD_WIDTH > 1) ? $clog2(DVD_WIDTH) : 1;

    logic                 busy;
    logic [CNT_WIDTH-1:0] cnt;
    logic [DVD_WIDTH-1:0] dvd_q;
    logic [DVS_WIDTH-1:0] dvs_q;
    logic [DVS_WIDTH-1:0] rem_q;
    logic [DVS_WIDTH:0]   shifted;
    logic                 ge;

    // quotient bits shift into the dividend register as its bits are consumed
    always_comb begin
        shifted   = {rem_q, dvd_q[DVD_WIDTH-1]};
        ge        = (shifted >= {1'b0, dvs_q});
        remainder = ge ? DVS_WIDTH'(shifted - {1'b0, dvs_q}) : shifted[DVS_WIDTH-1:0];
        quotient  = {dvd_q[DVD_WIDTH-2:0], ge};
    end

    assign done = busy && (cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            busy  <= 1'b0;
            cnt   <= '0;
            dvd_q <= '0;
            dvs_q <= '0;
            rem_q <= '0;
        end else if (start) begin
            busy  <= 1'b1;
            cnt   <= CNT_WIDTH'(DVD_WIDTH - 1);
            dvd_q <= dividend;
            dvs_q <= divisor;
            rem_q <= '0;
        end else if (busy) begin
            dvd_q <= quotient;
            rem_q <= remainder;
            cnt   <= cnt - CNT_WIDTH'(1);
            if (cnt == '0)
                busy <= 1'b0;
        end
    end

endmodule

// File: rtl/drr_req_gen.sv
// DRR request generator: weight lookup + pkt_len/weight divide; DRR_REQ_GEN_STATS_EN adds request counters.
// Latency: req_valid PKT_WIDTH+2 cycles after the descriptor handshake (2 cycles for a zero weight).
// Backpressure: pkt_ready low from handshake until the request has been emitted; no buffering.
module drr_req_gen
    import drr_req_gen_pkg::*;
#(
    parameter int CLASS_WIDTH    = DFLT_CLASS_WIDTH,
    parameter int WEIGHT_WIDTH   = DFLT_WEIGHT_WIDTH,
    parameter int PKT_WIDTH      = DFLT_PKT_WIDTH,
    parameter int DEFAULT_WEIGHT = DFLT_DEFAULT_WEIGHT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    pkt_valid,
    output logic                    pkt_ready,
    input  logic [CLASS_WIDTH-1:0]  pkt_class_id,
    input  logic [PKT_WIDTH-1:0]    pkt_len,
    input  logic                    cfg_wr_en,
    input  logic [CLASS_WIDTH-1:0]  cfg_class_id,
    input  logic [WEIGHT_WIDTH-1:0] cfg_weight,
    output logic                    req_valid,
    output logic [CLASS_WIDTH-1:0]  req_class_id,
    output logic [WEIGHT_WIDTH-1:0] req_class_weight,
    output logic [WEIGHT_WIDTH-1:0] req_div_quotient,
    output logic [WEIGHT_WIDTH-1:0] req_div_remain
`ifdef DRR_REQ_GEN_STATS_EN
    ,
    output logic [31:0]             stat_req_cnt,
    output logic [31:0]             stat_zero_wt_cnt
`endif
);

    localparam int TBL_DEPTH = 2 ** CLASS_WIDTH;

    typedef struct packed {
        logic [CLASS_WIDTH-1:0] class_id;
        logic [PKT_WIDTH-1:0]   len;
    } desc_t;

    state_t                  state;
    desc_t                   desc_q;
    logic [WEIGHT_WIDTH-1:0] wt_tbl [TBL_DEPTH];
    logic [WEIGHT_WIDTH-1:0] lookup_wt;
    logic [WEIGHT_WIDTH-1:0] wt_q;
    logic                    div_start;
    logic                    div_done;
    logic [PKT_WIDTH-1:0]    div_quo;
    logic [WEIGHT_WIDTH-1:0] div_rem;

    assign lookup_wt = wt_tbl[desc_q.class_id];
    // a zero divisor never starts the divider; the FSM jumps straight to EMIT
    assign div_start = (state == ST_LOOKUP) && (lookup_wt != '0);

    seq_restoring_div #(
        .DVD_WIDTH (PKT_WIDTH),
        .DVS_WIDTH (WEIGHT_WIDTH)
    ) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .dividend  (desc_q.len),
        .divisor   (lookup_wt),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= ST_IDLE;
            pkt_ready        <= 1'b1;
            desc_q           <= '0;
            wt_q             <= '0;
            req_valid        <= 1'b0;
            req_class_id     <= '0;
            req_class_weight <= '0;
            req_div_quotient <= '0;
            req_div_remain   <= '0;
            for (int i = 0; i < TBL_DEPTH; i++)
                wt_tbl[i] <= WEIGHT_WIDTH'(DEFAULT_WEIGHT);
        end else begin
            // a write coinciding with LOOKUP lands after the read, so LOOKUP sees the old entry
            if (cfg_wr_en)
                wt_tbl[cfg_class_id] <= cfg_weight;
            req_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pkt_valid) begin
                        desc_q    <= '{class_id: pkt_class_id, len: pkt_len};
                        pkt_ready <= 1'b0;
                        state     <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    wt_q <= lookup_wt;
                    if (lookup_wt == '0) begin
                        req_valid        <= 1'b1;
                        req_class_id     <= desc_q.class_id;
                        req_class_weight <= '0;
                        req_div_quotient <= '1;
                        req_div_remain   <= '0;
                        state            <= ST_EMIT;
                    end else begin
                        state <= ST_DIV;
                    end
                end
                ST_DIV: begin
                    if (div_done) begin
                        req_valid        <= 1'b1;
                        req_class_id     <= desc_q.class_id;
                        req_class_weight <= wt_q;
                        req_div_quotient <= WEIGHT_WIDTH'(div_quo);
                        req_div_remain   <= div_rem;
                        state            <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    pkt_ready <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: begin
                    pkt_ready <= 1'b1;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef DRR_REQ_GEN_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_req_cnt     <= '0;
            stat_zero_wt_cnt <= '0;
        end else if (req_valid) begin
            stat_req_cnt <= stat_req_cnt + 32'd1;
            if (req_class_weight == '0)
                stat_zero_wt_cnt <= stat_zero_wt_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_drr_req_gen.sv
// Scoreboard bench for drr_req_gen: directed descriptors push expected requests, a negedge monitor pops them.
module tb_drr_req_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pkt_valid = 1'b0;
    logic        pkt_ready;
    logic [4:0]  pkt_class_id = '0;
    logic [15:0] pkt_len = '0;
    logic        cfg_wr_en = 1'b0;
    logic [4:0]  cfg_class_id = '0;
    logic [15:0] cfg_weight = '0;
    logic        req_valid;
    logic [4:0]  req_class_id;
    logic [15:0] req_class_weight;
    logic [15:0] req_div_quotient;
    logic [15:0] req_div_remain;
`ifdef DRR_REQ_GEN_STATS_EN
    logic [31:0] stat_req_cnt;
    logic [31:0] stat_zero_wt_cnt;
`endif

    drr_req_gen dut (
        .clk              (clk),
        .rst              (rst),
        .pkt_valid        (pkt_valid),
        .pkt_ready        (pkt_ready),
        .pkt_class_id     (pkt_class_id),
        .pkt_len          (pkt_len),
        .cfg_wr_en        (cfg_wr_en),
        .cfg_class_id     (cfg_class_id),
        .cfg_weight       (cfg_weight),
        .req_valid        (req_valid),
        .req_class_id     (req_class_id),
        .req_class_weight (req_class_weight),
        .req_div_quotient (req_div_quotient),
        .req_div_remain   (req_div_remain)
`ifdef DRR_REQ_GEN_STATS_EN
        ,
        .stat_req_cnt     (stat_req_cnt),
        .stat_zero_wt_cnt (stat_zero_wt_cnt)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [4:0]  cls;
        logic [15:0] w;
        logic [15:0] q;
        logic [15:0] r;
        int          cyc;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d (0x%0h) required=%0d (0x%0h) at cyc=%0d", name, act, act, exp, exp, cyc);
        end
    endtask

    // monitor: every req_valid must match the oldest outstanding expectation
    exp_t e;
    always @(negedge clk) begin
        if (req_valid) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_req actual=req_valid 1 required=no request at cyc=%0d", cyc);
            end else begin
                e = sb.pop_front();
                chk("req_cycle",    cyc,              e.cyc);
                chk("req_class_id", req_class_id,     e.cls);
                chk("req_weight",   req_class_weight, e.w);
                chk("req_quotient", req_div_quotient, e.q);
                chk("req_remain",   req_div_remain,   e.r);
            end
        end
    end

    task automatic cfg_write(input logic [4:0] c, input logic [15:0] w);
        @(negedge clk);
        cfg_wr_en    = 1'b1;
        cfg_class_id = c;
        cfg_weight   = w;
        @(negedge clk);
        cfg_wr_en    = 1'b0;
    endtask

    // lat: negedges from the ready-detect negedge to the req_valid negedge
    task automatic send(input logic [4:0] c, input logic [15:0] len, input bit expect_req,
                        input logic [15:0] w, input logic [15:0] q, input logic [15:0] r,
                        input int lat, input bit hold);
        int n;
        n = 0;
        @(negedge clk);
        while (!pkt_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!pkt_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=pkt_ready 0 required=1 within 200 cycles at cyc=%0d", cyc);
        end else begin
            pkt_valid    = 1'b1;
            pkt_class_id = c;
            pkt_len      = len;
            if (expect_req)
                sb.push_back('{c, w, q, r, cyc + lat});
            @(posedge clk);
            #1;
            if (!hold)
                pkt_valid = 1'b0;
        end
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("rst_pkt_ready",  pkt_ready,        1);
        chk("rst_req_valid",  req_valid,        0);
        chk("rst_req_class",  req_class_id,     0);
        chk("rst_req_weight", req_class_weight, 0);
        chk("rst_req_quot",   req_div_quotient, 0);
        chk("rst_req_rem",    req_div_remain,   0);
        rst = 1'b0;

        cfg_write(5'd3, 16'd100);
        cfg_write(5'd7, 16'd64);
        cfg_write(5'd2, 16'd0);
        cfg_write(5'd5, 16'd100);

        send(5'd3, 16'd1500, 1'b1, 16'd100, 16'd15, 16'd0, 18, 1'b0);

        send(5'd7, 16'd1514, 1'b1, 16'd64, 16'd23, 16'd42, 18, 1'b0);
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            chk("busy_pkt_ready", pkt_ready, 0);
        end
        @(negedge clk);
        chk("reready_pkt_ready", pkt_ready, 1);

        send(5'd2, 16'd900, 1'b1, 16'd0, 16'hFFFF, 16'd0, 2, 1'b0);
        repeat (3) @(negedge clk);
`ifdef DRR_REQ_GEN_STATS_EN
        chk("stat_zero_wt_cnt", stat_zero_wt_cnt, 1);
        chk("stat_req_cnt",     stat_req_cnt,     3);
`endif

        send(5'd3, 16'd0, 1'b1, 16'd100, 16'd0, 16'd0, 18, 1'b0);

        send(5'd5, 16'd1000, 1'b1, 16'd100, 16'd10, 16'd0, 18, 1'b0);
        repeat (4) @(negedge clk);
        cfg_write(5'd5, 16'd200);
        send(5'd5, 16'd1000, 1'b1, 16'd200, 16'd5, 16'd0, 18, 1'b0);

        send(5'd9, 16'd64,  1'b1, 16'd1500, 16'd0, 16'd64,  18, 1'b1);
        send(5'd9, 16'd128, 1'b1, 16'd1500, 16'd0, 16'd128, 18, 1'b1);
        send(5'd9, 16'd256, 1'b1, 16'd1500, 16'd0, 16'd256, 18, 1'b0);

        // abort a request mid-divide; class 3 must come back at the default weight
        send(5'd3, 16'd3000, 1'b0, 16'd0, 16'd0, 16'd0, 18, 1'b0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_pkt_ready", pkt_ready, 1);
        chk("midrst_req_valid", req_valid, 0);
        repeat (25) @(negedge clk);
        send(5'd3, 16'd3000, 1'b1, 16'd1500, 16'd2, 16'd0, 18, 1'b0);

        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain actual=%0d outstanding required=0", sb.size());
        end
        repeat (2) @(negedge clk);
`ifdef DRR_REQ_GEN_STATS_EN
        chk("stat_req_cnt_final",  stat_req_cnt,     1);
        chk("stat_zero_cnt_final", stat_zero_wt_cnt, 0);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
